// File: rtl/sram_port_arbiter.sv
// Two-master arbiter sharing the base and ext board SRAMs between the IF-stage fetch
// port and the MEM-stage data port. Grants are combinational, read data returns one
// cycle after the grant, and a starvation counter guarantees fetch forward progress.
module sram_port_arbiter #(
  parameter int unsigned SEL_BIT    = 22,
  parameter int unsigned AW         = 20,
  parameter int unsigned MAX_STARVE = 3
) (
  input  logic          clk,
  input  logic          resetn,
  // Fetch port (read only)
  input  logic          if_req,
  input  logic [31:0]   if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [31:0]   if_rdata,
  // Data port
  input  logic          mem_req,
  input  logic [3:0]    mem_we,
  input  logic [31:0]   mem_addr,
  input  logic [31:0]   mem_wdata,
  output logic          mem_gnt,
  output logic          mem_rvalid,
  output logic [31:0]   mem_rdata,
  // Base RAM
  output logic          base_en,
  output logic [3:0]    base_we,
  output logic [AW-1:0] base_addr,
  output logic [31:0]   base_wdata,
  input  logic [31:0]   base_rdata,
  // Ext RAM
  output logic          ext_en,
  output logic [3:0]    ext_we,
  output logic [AW-1:0] ext_addr,
  output logic [31:0]   ext_wdata,
  input  logic [31:0]   ext_rdata
);

  localparam logic [3:0] MaxStarve = 4'(MAX_STARVE);

  logic          tgt_if;
  logic          tgt_mem;
  logic          conflict;
  logic          if_pri;
  logic [AW-1:0] if_waddr;
  logic [AW-1:0] mem_waddr;
  logic          mem_is_read;

  logic [3:0]    starve_q, starve_d;
  logic          if_rvalid_q, if_src_q;
  logic          mem_rvalid_q, mem_src_q;

  // Address bits above the select bit and the byte offset never reach the RAMs.
  logic          unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:SEL_BIT+1], if_addr[1:0],
                              mem_addr[31:SEL_BIT+1], mem_addr[1:0]};

  assign tgt_if      = if_addr[SEL_BIT];
  assign tgt_mem     = mem_addr[SEL_BIT];
  assign if_waddr    = if_addr[SEL_BIT-1:2];
  assign mem_waddr   = mem_addr[SEL_BIT-1:2];
  assign mem_is_read = (mem_we == 4'b0000);

  // Grant decode: MEM wins a same-RAM conflict unless fetch has starved long enough.
  // Nothing is granted while reset is asserted.
  always_comb begin
    conflict = if_req & mem_req & (tgt_if == tgt_mem);
    if_pri   = (starve_q == MaxStarve);
    if_gnt   = resetn & if_req  & ~(conflict & ~if_pri);
    mem_gnt  = resetn & mem_req & ~(conflict & if_pri);
  end

  // Starvation counter next state: clear on fetch grant, saturating count on denial.
  always_comb begin
    starve_d = starve_q;
    if (if_gnt) begin
      starve_d = 4'd0;
    end else if (if_req && (starve_q != MaxStarve)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  // RAM drive: each RAM follows whichever granted requester targets it, else idles at 0.
  always_comb begin
    base_en    = 1'b0;
    base_we    = 4'b0000;
    base_addr  = '0;
    base_wdata = 32'h0;
    ext_en     = 1'b0;
    ext_we     = 4'b0000;
    ext_addr   = '0;
    ext_wdata  = 32'h0;
    if (if_gnt) begin
      if (tgt_if) begin
        ext_en    = 1'b1;
        ext_addr  = if_waddr;
      end else begin
        base_en   = 1'b1;
        base_addr = if_waddr;
      end
    end
    // Arbitration guarantees the two grants never share a RAM.
    if (mem_gnt) begin
      if (tgt_mem) begin
        ext_en     = 1'b1;
        ext_we     = mem_we;
        ext_addr   = mem_waddr;
        ext_wdata  = mem_wdata;
      end else begin
        base_en    = 1'b1;
        base_we    = mem_we;
        base_addr  = mem_waddr;
        base_wdata = mem_wdata;
      end
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_q <= 4'd0;
    end else begin
      starve_q <= starve_d;
    end
  end

  // Response tracking: remember which RAM each granted read went to. Stores get no rvalid.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      if_rvalid_q  <= 1'b0;
      if_src_q     <= 1'b0;
      mem_rvalid_q <= 1'b0;
      mem_src_q    <= 1'b0;
    end else begin
      if_rvalid_q  <= if_gnt;
      if_src_q     <= tgt_if;
      mem_rvalid_q <= mem_gnt & mem_is_read;
      mem_src_q    <= tgt_mem;
    end
  end

  // Read data return: steer the RAM that served the read, zero when not valid.
  always_comb begin
    if_rvalid  = if_rvalid_q;
    mem_rvalid = mem_rvalid_q;
    if_rdata   = 32'h0;
    mem_rdata  = 32'h0;
    if (if_rvalid_q) begin
      if_rdata = if_src_q ? ext_rdata : base_rdata;
    end
    if (mem_rvalid_q) begin
      mem_rdata = mem_src_q ? ext_rdata : base_rdata;
    end
  end

  // A RAM is never claimed by both ports in the same cycle.
  a_no_double_grant: assert property (@(posedge clk) disable iff (!resetn)
    !(if_gnt && mem_gnt && (tgt_if == tgt_mem)));

  // A starved fetch always wins within one cycle of reaching the limit.
  a_if_progress: assert property (@(posedge clk) disable iff (!resetn)
    (if_req && starve_q == MaxStarve) |-> if_gnt);

endmodule
